// File: rtl/ctrl_quant_pkg.sv
// Shared types and helpers for the quantization shift/round sequencer.
package ctrl_quant_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Shift-count width for a given activation/weight precision pair.
  function automatic int calc_cw(input int pa, input int pw);
    return $clog2(pa * pw);
  endfunction

endpackage

// File: rtl/ctrl_quant_lane.sv
// One AC3 channel: registered shift/round enables driven from the shared counter.
module ctrl_quant_lane #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_shift,
  input  logic          i_round,
  input  logic [CW-1:0] i_cnt,
  input  logic [CW-1:0] i_max,
  output logic          o_s_en,
  output logic          o_rnd_en
);

  logic r_s_en;
  logic r_rnd_en;

  // Inputs are next-cycle state and count, so the flops line up with the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_en   <= 1'b0;
      r_rnd_en <= 1'b0;
    end else begin
      r_s_en   <= i_shift && (i_cnt < i_max);
      r_rnd_en <= i_round && (i_max != '0);
    end
  end

  assign o_s_en   = r_s_en;
  assign o_rnd_en = r_rnd_en;

endmodule

// File: rtl/ctrl_quant_seq.sv
// Sequences per-channel AC3 shift and rounding enables after a computation-done pulse.
module ctrl_quant_seq
  import ctrl_quant_pkg::*;
#(
  parameter  int Pa   = 8,
  parameter  int Pw   = 4,
  parameter  int N_CH = 4,
  localparam int CW   = calc_cw(Pa, Pw)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_load,
  input  logic [N_CH*CW-1:0] max_val,
  input  logic             round_mode,
  input  logic             cnt_start,
  input  logic             cnt_clear,
  output logic [N_CH-1:0]  s_en_ac3,
  output logic [N_CH-1:0]  rnd_en_ac3,
  output logic             done_quant,
  output logic             busy
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [CW-1:0]       w_cnt_inc;
  logic [N_CH*CW-1:0]  r_max;
  logic                r_mode;
  logic [CW-1:0]       w_max_all;
  logic                w_load_ok;
  logic                r_done;
  logic                r_busy;

  always_comb begin
    w_max_all = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (r_max[c*CW +: CW] > w_max_all) w_max_all = r_max[c*CW +: CW];
    end
  end

  // Shadow registers are frozen while a sequence runs; clear outranks load.
  assign w_load_ok = cnt_load && !cnt_clear &&
                     ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max  <= '0;
      r_mode <= 1'b0;
    end else if (w_load_ok) begin
      r_max  <= max_val;
      r_mode <= round_mode;
    end
  end

  assign w_cnt_inc = r_cnt + CW'(1);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    if (cnt_clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (cnt_start && !cnt_load) begin
            if (w_max_all != '0) w_state_nxt = ST_SHIFT;
            else if (r_mode)     w_state_nxt = ST_ROUND;
            else                 w_state_nxt = ST_DONE;
          end
        end
        ST_SHIFT: begin
          if (w_cnt_inc == w_max_all) w_state_nxt = r_mode ? ST_ROUND : ST_DONE;
          else                        w_cnt_nxt   = w_cnt_inc;
        end
        ST_ROUND: w_state_nxt = ST_DONE;
        ST_DONE:  w_state_nxt = ST_DONE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= (w_state_nxt == ST_DONE);
      r_busy  <= (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_ROUND);
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    ctrl_quant_lane #(
      .CW (CW)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_shift  (w_state_nxt == ST_SHIFT),
      .i_round  (w_state_nxt == ST_ROUND),
      .i_cnt    (w_cnt_nxt),
      .i_max    (r_max[c*CW +: CW]),
      .o_s_en   (s_en_ac3[c]),
      .o_rnd_en (rnd_en_ac3[c])
    );
  end

  assign done_quant = r_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_ctrl_quant_seq.sv
// Self-checking bench for ctrl_quant_seq: vector table plus scoreboard of per-cycle output frames.
module tb_ctrl_quant_seq;

  localparam int N_CH = 4;
  localparam int CW   = 5;
  localparam int FW   = 2 * N_CH + 2;

  typedef logic [FW-1:0]        frame_t;
  typedef logic [N_CH*CW-1:0]   maxv_t;

  typedef struct {
    maxv_t mv;
    logic  mode;
    int    hold;
    string tag;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             cnt_load;
  maxv_t            max_val;
  logic             round_mode;
  logic             cnt_start;
  logic             cnt_clear;
  logic [N_CH-1:0]  s_en_ac3;
  logic [N_CH-1:0]  rnd_en_ac3;
  logic             done_quant;
  logic             busy;

  int     total;
  int     bad;
  frame_t exp_q[$];
  vec_t   vecs[6];

  ctrl_quant_seq #(
    .Pa   (8),
    .Pw   (4),
    .N_CH (N_CH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_load   (cnt_load),
    .max_val    (max_val),
    .round_mode (round_mode),
    .cnt_start  (cnt_start),
    .cnt_clear  (cnt_clear),
    .s_en_ac3   (s_en_ac3),
    .rnd_en_ac3 (rnd_en_ac3),
    .done_quant (done_quant),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Channel list in ch0..ch3 order, matching how sequences are written down.
  function automatic maxv_t pack(input int m0, input int m1, input int m2, input int m3);
    return {CW'(m3), CW'(m2), CW'(m1), CW'(m0)};
  endfunction

  function automatic int max_of(input maxv_t mv);
    int mx;
    mx = 0;
    for (int c = 0; c < N_CH; c++) begin
      if (int'(mv[c*CW +: CW]) > mx) mx = int'(mv[c*CW +: CW]);
    end
    return mx;
  endfunction

  // Expected {s_en, rnd_en, done, busy} j cycles after the start edge.
  function automatic frame_t model(input maxv_t mv, input logic mode, input int j);
    logic [N_CH-1:0] s;
    logic [N_CH-1:0] r;
    int mx;
    int mr;
    int mc;
    mx = max_of(mv);
    mr = mx + (mode ? 1 : 0);
    for (int c = 0; c < N_CH; c++) begin
      mc   = int'(mv[c*CW +: CW]);
      s[c] = (j < mc);
      r[c] = mode && (j == mx) && (mc > 0);
    end
    return {s, r, (j >= mr), (j < mr)};
  endfunction

  task automatic check(input string name, input frame_t act, input frame_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got s/r/done/busy=%b want %b", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got %b want a queued frame", name,
               {s_en_ac3, rnd_en_ac3, done_quant, busy});
    end else begin
      check(name, {s_en_ac3, rnd_en_ac3, done_quant, busy}, exp_q.pop_front());
    end
  endtask

  task automatic expect_now(input string name, input frame_t exp);
    exp_q.push_back(exp);
    pop_check(name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input maxv_t mv, input logic mode);
    cnt_load   = 1'b1;
    max_val    = mv;
    round_mode = mode;
    step();
    cnt_load = 1'b0;
    expect_now("load_idle", '0);
  endtask

  task automatic do_clear(input string tag);
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    expect_now({tag, "_clear"}, '0);
  endtask

  // Start a sequence and compare every cycle up to done plus hold cycles.
  // disturb_j >= 0 injects a load of all-7 and a second start while running.
  task automatic run_start(input maxv_t mv, input logic mode, input int hold,
                           input int disturb_j, input string tag);
    int len;
    len = max_of(mv) + (mode ? 1 : 0) + hold + 1;
    for (int j = 0; j < len; j++) exp_q.push_back(model(mv, mode, j));
    cnt_start = 1'b1;
    step();
    cnt_start = 1'b0;
    for (int j = 0; j < len; j++) begin
      pop_check($sformatf("%s_j%0d", tag, j));
      if (j == disturb_j) begin
        cnt_load  = 1'b1;
        cnt_start = 1'b1;
        max_val   = pack(7, 7, 7, 7);
      end
      if (j < len - 1) step();
      if (j == disturb_j) begin
        cnt_load  = 1'b0;
        cnt_start = 1'b0;
      end
    end
  endtask

  initial begin
    maxv_t mv;
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    cnt_load   = 1'b0;
    max_val    = '0;
    round_mode = 1'b0;
    cnt_start  = 1'b0;
    cnt_clear  = 1'b0;

    vecs[0] = '{pack(3, 0, 5, 1),     1'b0, 3,  "v3051_m0"};
    vecs[1] = '{pack(3, 0, 5, 1),     1'b1, 3,  "v3051_m1"};
    vecs[2] = '{pack(0, 0, 0, 0),     1'b0, 10, "vzero_m0"};
    vecs[3] = '{pack(0, 0, 0, 0),     1'b1, 2,  "vzero_m1"};
    vecs[4] = '{pack(31, 31, 31, 31), 1'b0, 2,  "vmax_m0"};
    vecs[5] = '{pack(2, 7, 1, 4),     1'b1, 2,  "v2714_m1"};

    #12;
    expect_now("in_reset", '0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    expect_now("after_reset", '0);

    run_start('0, 1'b0, 2, -1, "start_no_load");
    do_clear("start_no_load");

    foreach (vecs[i]) begin
      do_load(vecs[i].mv, vecs[i].mode);
      run_start(vecs[i].mv, vecs[i].mode, vecs[i].hold, -1, vecs[i].tag);
      do_clear(vecs[i].tag);
    end

    // Load and restart while shifting are ignored; shadows survive clear.
    mv = pack(3, 0, 5, 1);
    do_load(mv, 1'b0);
    run_start(mv, 1'b0, 2, 1, "disturb");
    do_clear("disturb");
    run_start(mv, 1'b0, 1, -1, "retained");

    // A load taken in DONE keeps done asserted and is used by the next start.
    mv = pack(0, 2, 0, 0);
    cnt_load   = 1'b1;
    max_val    = mv;
    round_mode = 1'b1;
    step();
    cnt_load = 1'b0;
    expect_now("load_in_done", model('0, 1'b0, 0));
    do_clear("load_in_done");
    run_start(mv, 1'b1, 1, -1, "after_done_load");
    do_clear("after_done_load");

    // Clear and start together: clear wins and the block stays idle.
    do_load(pack(31, 31, 31, 31), 1'b0);
    cnt_clear = 1'b1;
    cnt_start = 1'b1;
    step();
    cnt_clear = 1'b0;
    cnt_start = 1'b0;
    expect_now("clear_vs_start", '0);
    step();
    expect_now("clear_vs_start_hold", '0);

    // Asynchronous reset during SHIFT, then a fresh start sees cleared shadows.
    mv = pack(3, 0, 5, 1);
    do_clear("pre_rst");
    do_load(mv, 1'b0);
    cnt_start = 1'b1;
    step();
    cnt_start = 1'b0;
    expect_now("rst_seq_j0", model(mv, 1'b0, 0));
    step();
    expect_now("rst_seq_j1", model(mv, 1'b0, 1));
    #2;
    rst_n = 1'b0;
    #1;
    expect_now("async_rst", '0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    expect_now("post_rst_idle", '0);
    run_start('0, 1'b0, 1, -1, "post_rst_start");

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover frames want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_quant_seq.md
CTRL_QUANT_SEQ -- requirements
Module: ctrl_quant_seq

Interface
REQ-001 Parameter Pa, default 8, activation precision in bits.
REQ-002 Parameter Pw, default 4, weight precision in bits.
REQ-003 Parameter N_CH, default 4, number of AC3 channels sequenced in parallel.
REQ-004 Derived constant CW = $clog2(Pa*Pw), the shift-count width.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 cnt_load  input  1  captures max_val and round_mode.
REQ-008 max_val  input  N_CH*CW  per-channel shift count; channel c occupies bits [c*CW +: CW].
REQ-009 round_mode  input  1  when 1, one rounding cycle follows the shifts.
REQ-010 cnt_start  input  1  pulse from AC3 computation done; starts the sequence.
REQ-011 cnt_clear  input  1  write-back complete; returns the block to IDLE.
REQ-012 s_en_ac3  output  N_CH  per-channel AC3 shift enable.
REQ-013 rnd_en_ac3  output  N_CH  per-channel AC3 rounding enable.
REQ-014 done_quant  output  1  quantization complete, status to the control FSM.
REQ-015 busy  output  1  high in SHIFT and ROUND.

Function
REQ-016 The FSM SHALL have states IDLE, SHIFT, ROUND and DONE; all outputs SHALL be registered.
REQ-017 Input priority SHALL be cnt_clear > cnt_load > cnt_start within a cycle.
REQ-018 cnt_load SHALL update the max/mode shadow registers only in IDLE or DONE, and SHALL be ignored in SHIFT or ROUND.
REQ-019 cnt_start SHALL be accepted only in IDLE; it SHALL be ignored in every other state.
REQ-020 On cnt_start, the FSM SHALL go to SHIFT if M = max over channels of max_reg is greater than 0; otherwise to ROUND if the captured round_mode is 1; otherwise to DONE.
REQ-021 In SHIFT, a shared counter cnt starts at 0 and increments by 1 each cycle; s_en_ac3[c] SHALL be 1 while cnt < max_reg[c].
REQ-022 SHIFT SHALL last exactly M cycles, then go to ROUND if round_mode is 1, else to DONE.
REQ-023 ROUND SHALL last 1 cycle with rnd_en_ac3[c] = 1 for every channel where max_reg[c] > 0, then go to DONE.
REQ-024 In DONE, done_quant SHALL be 1 and SHALL hold until cnt_clear; all enables SHALL be 0.
REQ-025 For a start sampled at edge k, s_en_ac3[c] SHALL be high on cycles k+1 .. k+max_reg[c].
REQ-026 For the same start, done_quant SHALL rise at cycle k+M+R+1, where R is the captured round_mode.
REQ-027 cnt_clear SHALL force IDLE from any state; all outputs SHALL read 0 on the next cycle, and the shadow registers SHALL be retained.
REQ-028 The maximum legal max_val is Pa*Pw-1; the counter SHALL never wrap.

Reset
REQ-029 When rst_n is low, the block SHALL be in IDLE with cnt = 0, max_reg = 0 and round_mode register = 0.
REQ-030 When rst_n is low, s_en_ac3, rnd_en_ac3, done_quant and busy SHALL all be 0.
REQ-031 Reset asserted mid-SHIFT SHALL drop all enables immediately.
REQ-032 After reset, a cnt_start with no prior cnt_load SHALL go to DONE in one cycle.

Structure
REQ-033 Package ctrl_quant_pkg SHALL hold the state enum and a CW helper function.
REQ-034 A sub-module ctrl_quant_lane (one instance per channel) SHALL compare cnt against its max_reg and generate s_en/rnd_en.

Verification
REQ-035 Load max = {3,0,5,1}, round_mode = 0, start -> s_en widths 3/0/5/1 cycles; done_quant rises at start+6.
REQ-036 Same load with round_mode = 1 -> rnd_en = 4'b1101 for 1 cycle after shifts; done_quant rises at start+7.
REQ-037 All max = 0, round_mode = 0 -> no enables; done_quant at start+1; hold 10 cycles; cnt_clear -> done_quant = 0 on the next cycle.
REQ-038 cnt_load {7,7,7,7} and a second cnt_start mid-SHIFT -> both ignored; the original counts complete.
REQ-039 rst_n asserted at SHIFT cycle 2 -> all outputs 0 asynchronously; a new start after reset gives done_quant at start+1.
REQ-040 Max = 31 on all channels (Pa*Pw-1) -> 31 enable cycles, no wrap; cnt_clear and cnt_start in the same cycle -> clear wins, block stays in IDLE.
